hilo_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for MIPS mult/multu/div/divu.
- Accepts an operation from the ID/EX stage and iterates one bit per cycle.
- Produces a single-cycle HI/LO write request toward the register file.
- Generates the pipeline stall when a later mfhi/mflo, or a new mul/div, would read or overwrite HI/LO before the result is ready.

---
 rtl/hilo_muldiv_seq_pkg.sv | 29 ++
 rtl/hilo_muldiv_seq_if.sv | 36 +++
 rtl/hilo_muldiv_seq_muldiv_step.sv | 39 +++
 rtl/hilo_muldiv_seq.sv | 135 +++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_muldiv_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// ID/EX issue port and HI/LO result port of the multiply/divide sequencer.
interface hilo_muldiv_seq_if
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_ID_EX_MulDiv_Start;
  logic [1:0]       in_ID_EX_MulDiv_Op;
  logic [WIDTH-1:0] in_ID_EX_Src_A;
  logic [WIDTH-1:0] in_ID_EX_Src_B;
  logic             in_ID_EX_mfhi;
  logic             in_ID_EX_mflo;
  logic             in_Flush;
  logic             out_MulDiv_Busy;
  logic             out_MulDiv_Stall;
  logic             out_HiLo_Write_Ctrl;
  logic [WIDTH-1:0] out_Hi_Data;
  logic [WIDTH-1:0] out_Lo_Data;
  logic             out_Div_By_Zero;

  modport master (
    output in_ID_EX_MulDiv_Start, in_ID_EX_MulDiv_Op, in_ID_EX_Src_A, in_ID_EX_Src_B,
           in_ID_EX_mfhi, in_ID_EX_mflo, in_Flush,
    input  out_MulDiv_Busy, out_MulDiv_Stall, out_HiLo_Write_Ctrl,
           out_Hi_Data, out_Lo_Data, out_Div_By_Zero
  );

  modport slave (
    input  in_ID_EX_MulDiv_Start, in_ID_EX_MulDiv_Op, in_ID_EX_Src_A, in_ID_EX_Src_B,
           in_ID_EX_mfhi, in_ID_EX_mflo, in_Flush,
    output out_MulDiv_Busy, out_MulDiv_Stall, out_HiLo_Write_Ctrl,
           out_Hi_Data, out_Lo_Data, out_Div_By_Zero
  );

endinterface

// File: rtl/hilo_muldiv_seq_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module hilo_muldiv_seq_muldiv_step
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   part,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   part_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = '0;
    div_diff  = '0;
    part_next = part;
    if (is_div) begin
      // part = {rem, quot}; rem < divisor so part[2W] stays 0 and the shift is exact
      div_diff = {1'b0, part[2*WIDTH-1:WIDTH-1]} - {2'b00, operand};
      if (div_diff[WIDTH+1]) begin
        part_next = {part[2*WIDTH-1:0], 1'b0};
      end else begin
        part_next = {div_diff[WIDTH:0], part[WIDTH-2:0], 1'b1};
      end
    end else begin
      // part = {acc, multiplier}; add on lsb then shift the whole pair right
      mul_sum = part[2*WIDTH:WIDTH] + {1'b0, operand};
      if (part[0]) begin
        part_next = {1'b0, mul_sum, part[WIDTH-1:1]};
      end else begin
        part_next = {1'b0, part[2*WIDTH:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// MIPS mult/multu/div/divu sequencer: one bit per cycle, single-cycle HI/LO write,
// and the stall for mfhi/mflo/new issue while an operation is in flight.
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_seq_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH + 1;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, opnd_q;
  logic             sa_q, sb_q;
  logic [PW-1:0]    part_q, part_next;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  hilo_muldiv_seq_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (op_is_div(op_q)),
    .part      (part_q),
    .operand   (opnd_q),
    .part_next (part_next)
  );

  // Magnitudes for signed ops; -2^(W-1) maps to its unsigned magnitude unchanged
  always_comb begin
    a_neg = op_is_signed(op_q) & a_q[WIDTH-1];
    b_neg = op_is_signed(op_q) & b_q[WIDTH-1];
    a_abs = a_neg ? WIDTH'(-a_q) : a_q;
    b_abs = b_neg ? WIDTH'(-b_q) : b_q;
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? (2*WIDTH)'(-part_q[2*WIDTH-1:0]) : part_q[2*WIDTH-1:0];
    quot_fix = (sa_q ^ sb_q) ? WIDTH'(-part_q[WIDTH-1:0]) : part_q[WIDTH-1:0];
    rem_fix  = sa_q ? WIDTH'(-part_q[2*WIDTH-1:WIDTH]) : part_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      opnd_q <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      part_q <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
    end else if (state != IDLE && bus.in_Flush) begin
      state <= IDLE;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_ID_EX_MulDiv_Start && !bus.in_Flush) begin
            op_q  <= op_e'(bus.in_ID_EX_MulDiv_Op);
            a_q   <= bus.in_ID_EX_Src_A;
            b_q   <= bus.in_ID_EX_Src_B;
            dbz_q <= 1'b0;
            state <= PREP;
          end
        end
        PREP: begin
          sa_q <= a_neg;
          sb_q <= b_neg;
          if (op_is_div(op_q) && b_q == '0) begin
            // FIX picks the raw-dividend result from dbz_q
            dbz_q <= 1'b1;
            state <= FIX;
          end else begin
            cnt_q <= CW'(WIDTH - 1);
            state <= RUN;
            if (op_is_div(op_q)) begin
              part_q <= {(WIDTH + 1)'(0), a_abs};
              opnd_q <= b_abs;
            end else begin
              part_q <= {(WIDTH + 1)'(0), b_abs};
              opnd_q <= a_abs;
            end
          end
        end
        RUN: begin
          part_q <= part_next;
          if (cnt_q == '0) begin
            state <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIX: begin
          if (dbz_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else if (op_is_div(op_q)) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush or reset arriving in DONE must still cancel the write that cycle
  assign bus.out_MulDiv_Busy     = (state != IDLE);
  assign bus.out_MulDiv_Stall    = (state != IDLE) &
                                   (bus.in_ID_EX_mfhi | bus.in_ID_EX_mflo | bus.in_ID_EX_MulDiv_Start);
  assign bus.out_HiLo_Write_Ctrl = (state == DONE) & ~bus.in_Flush & ~rst;
  assign bus.out_Hi_Data         = hi_q;
  assign bus.out_Lo_Data         = lo_q;
  assign bus.out_Div_By_Zero     = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed + random scoreboard bench for hilo_muldiv_seq.
module tb_hilo_muldiv_seq;
  import hilo_muldiv_seq_pkg::*;

  localparam int unsigned W = DEF_WIDTH;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_seq_if #(.WIDTH(W)) bus ();

  hilo_muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model built on 64-bit host arithmetic
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    e.lat = int'(W) + 3;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    if (op[1] && b == '0) begin
      e.dbz = 1'b1;
      e.hi  = a;
      e.lo  = '1;
      e.lat = 3;
    end else if (op[1]) begin
      q = op[0] ? ua / ub : sa / sb;
      r = op[0] ? ua % ub : sa % sb;
      e.lo = W'(q);
      e.hi = W'(r);
    end else begin
      p = op[0] ? 64'(ua * ub) : 64'(sa * sb);
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse Start for one edge; afterwards cyc = 1 (first busy cycle)
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result);
    if (expect_result) sb_q.push_back(model(op, a, b));
    bus.in_ID_EX_MulDiv_Op    = op;
    bus.in_ID_EX_Src_A        = a;
    bus.in_ID_EX_Src_B        = b;
    bus.in_ID_EX_MulDiv_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.in_ID_EX_MulDiv_Start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_write(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      chk($sformatf("%s busy", tag), 64'(bus.out_MulDiv_Busy), 64'd1);
      if (bus.out_HiLo_Write_Ctrl) seen = 1'b1;
      else step();
    end
    chk($sformatf("%s write_seen", tag), 64'(seen), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen) begin
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(e.lat));
        chk($sformatf("%s hi", tag), 64'(bus.out_Hi_Data), 64'(e.hi));
        chk($sformatf("%s lo", tag), 64'(bus.out_Lo_Data), 64'(e.lo));
        chk($sformatf("%s dbz", tag), 64'(bus.out_Div_By_Zero), 64'(e.dbz));
      end
    end
    step();
    chk($sformatf("%s idle_after", tag), 64'(bus.out_MulDiv_Busy), 64'd0);
    chk($sformatf("%s no_write_after", tag), 64'(bus.out_HiLo_Write_Ctrl), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s busy", tag),  64'(bus.out_MulDiv_Busy), 64'd0);
    chk($sformatf("%s stall", tag), 64'(bus.out_MulDiv_Stall), 64'd0);
    chk($sformatf("%s write", tag), 64'(bus.out_HiLo_Write_Ctrl), 64'd0);
    chk($sformatf("%s hi", tag),    64'(bus.out_Hi_Data), 64'd0);
    chk($sformatf("%s lo", tag),    64'(bus.out_Lo_Data), 64'd0);
    chk($sformatf("%s dbz", tag),   64'(bus.out_Div_By_Zero), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bit           wr_seen;

    rst = 1'b1;
    bus.in_ID_EX_MulDiv_Start = 1'b0;
    bus.in_ID_EX_MulDiv_Op    = 2'b00;
    bus.in_ID_EX_Src_A        = '0;
    bus.in_ID_EX_Src_B        = '0;
    bus.in_ID_EX_mfhi         = 1'b0;
    bus.in_ID_EX_mflo         = 1'b0;
    bus.in_Flush              = 1'b0;
    step();
    step();
    chk_all_zero("reset");

    // Start in the first cycle after reset release
    rst = 1'b0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
    wait_write("multu_ffffffff_x2");

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_write("mult_m3_x7");
    issue(OP_MULT, 32'd7, 32'd3, 1'b1);
    wait_write("mult_7_x3");
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_write("div_7_m2");
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_write("div_m7_2");
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_write("div_min_m1");
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_write("mult_min_min");

    // Divide by zero: short path, sticky flag cleared by next accepted start
    issue(OP_DIVU, 32'd9, 32'd0, 1'b1);
    wait_write("divu_9_0");
    chk("dbz_sticky", 64'(bus.out_Div_By_Zero), 64'd1);
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_write("div_m16_0");
    issue(OP_MULTU, 32'd5, 32'd6, 1'b1);
    chk("dbz_cleared_on_start", 64'(bus.out_Div_By_Zero), 64'd0);
    wait_write("multu_5_6");

    // mfhi from cycle 10 and a re-issue attempt in cycles 12-14
    issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    while (cyc < 35) begin
      bus.in_ID_EX_mfhi = (cyc >= 10);
      bus.in_ID_EX_MulDiv_Start = (cyc >= 12 && cyc <= 14);
      bus.in_ID_EX_MulDiv_Op = OP_DIVU;
      bus.in_ID_EX_Src_A = 32'd100;
      bus.in_ID_EX_Src_B = 32'd0;
      #1;
      chk($sformatf("stall_c%0d", cyc), 64'(bus.out_MulDiv_Stall), 64'(cyc >= 10));
      step();
    end
    bus.in_ID_EX_MulDiv_Start = 1'b0;
    #1;
    chk("stall_write_cycle", 64'(bus.out_MulDiv_Stall), 64'd1);
    wait_write("mult_under_stall");
    chk("stall_released", 64'(bus.out_MulDiv_Stall), 64'd0);
    bus.in_ID_EX_mfhi = 1'b0;

    // mflo alone also stalls
    issue(OP_DIVU, 32'd1000, 32'd7, 1'b1);
    bus.in_ID_EX_mflo = 1'b1;
    #1;
    chk("stall_mflo", 64'(bus.out_MulDiv_Stall), 64'd1);
    bus.in_ID_EX_mflo = 1'b0;
    wait_write("divu_1000_7");

    // Flush at cycle 20: no write, idle at 21
    issue(OP_MULT, 32'd11, 32'd13, 1'b0);
    while (cyc < 20) step();
    bus.in_Flush = 1'b1;
    step();
    bus.in_Flush = 1'b0;
    chk("flush_busy_c21", 64'(bus.out_MulDiv_Busy), 64'd0);
    wr_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr_seen |= bus.out_HiLo_Write_Ctrl;
      step();
    end
    chk("flush_no_write", 64'(wr_seen), 64'd0);

    // Flush in DONE cancels the write in that same cycle
    issue(OP_MULTU, 32'd3, 32'd3, 1'b0);
    while (cyc < 35) step();
    bus.in_Flush = 1'b1;
    #1;
    chk("flush_done_write", 64'(bus.out_HiLo_Write_Ctrl), 64'd0);
    step();
    bus.in_Flush = 1'b0;
    chk("flush_done_idle", 64'(bus.out_MulDiv_Busy), 64'd0);

    // Flush with Start in IDLE: nothing accepted
    bus.in_ID_EX_MulDiv_Start = 1'b1;
    bus.in_Flush = 1'b1;
    step();
    bus.in_ID_EX_MulDiv_Start = 1'b0;
    bus.in_Flush = 1'b0;
    chk("flush_beats_start", 64'(bus.out_MulDiv_Busy), 64'd0);

    // Flush on the divide-by-zero path clears the flag
    issue(OP_DIVU, 32'd9, 32'd0, 1'b0);
    step();
    chk("dbz_set_c2", 64'(bus.out_Div_By_Zero), 64'd1);
    bus.in_Flush = 1'b1;
    step();
    bus.in_Flush = 1'b0;
    chk("dbz_flush_clear", 64'(bus.out_Div_By_Zero), 64'd0);
    chk("dbz_flush_write", 64'(bus.out_HiLo_Write_Ctrl), 64'd0);
    chk("dbz_flush_busy", 64'(bus.out_MulDiv_Busy), 64'd0);

    // Reset at cycle 15 mid-operation
    issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0);
    while (cyc < 15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_mid_op");
    wr_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr_seen |= bus.out_HiLo_Write_Ctrl;
      step();
    end
    chk("rst_no_write", 64'(wr_seen), 64'd0);

    // Random operations against the model
    for (int k = 0; k < 10; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k == 4) ? 32'd0 : ((k % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom));
      issue(rop, ra, rb, 1'b1);
      wait_write($sformatf("rand%0d_op%0d", k, rop));
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
